// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions for the dummy DDR model
// and the cache-side traffic sources that talk to it.
package mem_if_pkg;

    localparam int MEM_DATA_W = 256;
    localparam int MEM_ADDR_W = 28;
    localparam logic MEM_RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/ddr_dummy_tag_match.sv
// Fully-associative tag lookup: parallel compares of the command
// address against every live entry, with one-hot to binary index.
module ddr_dummy_tag_match
    import mem_if_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [MEM_ADDR_W-1:0] tags [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (tags[i] == addr);
        end
    end

    assign hit = |match;

    // At most one bit of match is set, so OR-ing indices is exact
    always_comb begin
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ddr_dummy_mem.sv
// Behavioural DDR stand-in: one 256-bit line per handshake, small
// fully-associative line store, fixed-latency completion pulse.
module ddr_dummy_mem
    import mem_if_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH = 16,
    parameter logic [MEM_DATA_W-1:0] FILL_PATTERN = {8{32'hDEAD_BEEF}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_DATA_W-1:0] mem_data_wr,
    input  logic [MEM_ADDR_W-1:0] mem_data_addr,
    input  logic                  mem_rw_data,
    input  logic                  mem_valid_data,
    output logic [MEM_DATA_W-1:0] mem_data_rd,
    output logic                  mem_ready_data,
    output logic                  rd_miss,
    output logic                  evict,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [5:0] CNT_INIT = 6'(LATENCY - 1);

    state_t state;
    state_t state_nxt;
    logic [5:0] cnt;
    logic take;
    logic commit;

    logic                  cap_rw;
    logic [MEM_ADDR_W-1:0] cap_addr;
    logic [MEM_DATA_W-1:0] cap_wdata;
    logic                  cmd_rw;
    logic [MEM_ADDR_W-1:0] cmd_addr;
    logic [MEM_DATA_W-1:0] cmd_wdata;

    logic [MEM_ADDR_W-1:0] tags  [DEPTH];
    logic [MEM_DATA_W-1:0] lines [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      hit_idx;
    logic                  hit;
    logic                  do_wr;
    logic                  do_rd;

    assign take = (state == ST_IDLE) && mem_valid_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mem_valid_data) begin
                    state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    commit    = (LATENCY == 1);
                end
            end
            ST_WAIT: begin
                if (cnt == 6'd1) begin
                    state_nxt = ST_RESP;
                    commit    = 1'b1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= CNT_INIT;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            cap_rw    <= mem_rw_data;
            cap_addr  <= mem_data_addr;
            cap_wdata <= mem_data_wr;
        end
    end

    // With LATENCY=1 the commit edge is also the capture edge
    assign cmd_rw    = (state == ST_IDLE) ? mem_rw_data   : cap_rw;
    assign cmd_addr  = (state == ST_IDLE) ? mem_data_addr : cap_addr;
    assign cmd_wdata = (state == ST_IDLE) ? mem_data_wr   : cap_wdata;

    assign do_wr = commit && (cmd_rw == MEM_RW_WRITE);
    assign do_rd = commit && (cmd_rw != MEM_RW_WRITE);

    ddr_dummy_tag_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .addr  (cmd_addr),
        .tags  (tags),
        .valid (valid),
        .hit   (hit),
        .idx   (hit_idx)
    );

    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            if (hit) begin
                lines[hit_idx] <= cmd_wdata;
            end else begin
                tags[ptr]  <= cmd_addr;
                lines[ptr] <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            ptr         <= '0;
            evict       <= 1'b0;
            rd_miss     <= 1'b0;
            wr_count    <= '0;
            rd_count    <= '0;
            mem_data_rd <= '0;
        end else begin
            if (do_wr) begin
                wr_count <= wr_count + 16'd1;
                if (!hit) begin
                    valid[ptr] <= 1'b1;
                    ptr        <= ptr + IDX_W'(1);
                    if (valid[ptr]) begin
                        evict <= 1'b1;
                    end
                end
            end
            if (do_rd) begin
                rd_count <= rd_count + 16'd1;
                if (hit) begin
                    mem_data_rd <= lines[hit_idx];
                end else begin
                    mem_data_rd <= FILL_PATTERN;
                    rd_miss     <= 1'b1;
                end
            end
        end
    end

    assign mem_ready_data = (state == ST_RESP);

endmodule

// File: tb/tb_ddr_dummy_mem.sv
// Randomized + directed bench for ddr_dummy_mem against a
// cycle-scheduled behavioural line-store model.
module tb_ddr_dummy_mem;

    localparam int LAT = 4;
    localparam int DEPTH = 16;
    localparam logic [255:0] FILL = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] D1 = {32'h1111_1111, 32'h2222_2222,
                                   32'h3333_3333, 32'h4444_4444,
                                   32'h5555_5555, 32'h6666_6666,
                                   32'h7777_7777, 32'h8888_8888};
    localparam logic [255:0] D5 = {32'h0A0A_0A0A, 32'h1B1B_1B1B,
                                   32'h2C2C_2C2C, 32'h3D3D_3D3D,
                                   32'h0A0A_0A0A, 32'h1B1B_1B1B,
                                   32'h2C2C_2C2C, 32'h3FBA_BAF1};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] wr_d = '0;
    logic [27:0]  addr = '0;
    logic         rw = 1'b0;
    logic         valid = 1'b0;

    logic [255:0] mem_data_rd;
    logic         mem_ready_data;
    logic         rd_miss;
    logic         evict;
    logic [15:0]  wr_count;
    logic [15:0]  rd_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ddr_dummy_mem #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_data_wr    (wr_d),
        .mem_data_addr  (addr),
        .mem_rw_data    (rw),
        .mem_valid_data (valid),
        .mem_data_rd    (mem_data_rd),
        .mem_ready_data (mem_ready_data),
        .rd_miss        (rd_miss),
        .evict          (evict),
        .wr_count       (wr_count),
        .rd_count       (rd_count)
    );

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [27:0]  mtag [DEPTH];
    logic [255:0] mdat [DEPTH];
    bit           mval [DEPTH];
    int           mptr;
    bit           m_evict;
    bit           m_miss;
    logic [15:0]  m_wr;
    logic [15:0]  m_rd;
    logic [255:0] m_rd_data;
    bit           exp_ready;
    bit           started = 1'b0;
    longint       cyc = 0;
    bit           pend = 1'b0;
    longint       done_cyc = 0;
    longint       free_cyc = 0;
    logic         p_rw;
    logic [27:0]  p_addr;
    logic [255:0] p_data;

    task automatic model_apply();
        int h;
        h = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mval[i] && mtag[i] == p_addr) h = i;
        end
        if (p_rw) begin
            m_wr = m_wr + 16'd1;
            if (h >= 0) begin
                mdat[h] = p_data;
            end else begin
                if (mval[mptr]) m_evict = 1'b1;
                mtag[mptr] = p_addr;
                mdat[mptr] = p_data;
                mval[mptr] = 1'b1;
                mptr = (mptr + 1) % DEPTH;
            end
        end else begin
            m_rd = m_rd + 16'd1;
            if (h >= 0) begin
                m_rd_data = mdat[h];
            end else begin
                m_rd_data = FILL;
                m_miss = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started = 1'b1;
            for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;
            mptr = 0;
            m_evict = 1'b0;
            m_miss = 1'b0;
            m_wr = '0;
            m_rd = '0;
            m_rd_data = '0;
            pend = 1'b0;
            exp_ready = 1'b0;
            free_cyc = cyc + 1;
        end else begin
            exp_ready = 1'b0;
            if (!pend && cyc >= free_cyc && valid) begin
                pend = 1'b1;
                p_rw = rw;
                p_addr = addr;
                p_data = wr_d;
                done_cyc = cyc + LAT - 1;
                free_cyc = cyc + LAT + 1;
            end
            if (pend && cyc == done_cyc) begin
                model_apply();
                pend = 1'b0;
                exp_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready", mem_ready_data, exp_ready);
            check("rd_data", mem_data_rd, m_rd_data);
            check("rd_miss", rd_miss, m_miss);
            check("evict", evict, m_evict);
            check("wr_count", wr_count, m_wr);
            check("rd_count", rd_count, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_cmd(input logic w, input logic [27:0] a,
                          input logic [255:0] d, output int lat);
        rw = w;
        addr = a;
        wr_d = d;
        valid = 1'b1;
        lat = 0;
        for (int i = 1; i <= 4 * LAT + 20; i++) begin
            @(negedge clk);
            if (mem_ready_data) begin
                lat = i;
                break;
            end
        end
        check("cmd_done", lat != 0, 1'b1);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [255:0] pat(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    function automatic logic [27:0] pool(input int i);
        if (i < 12) return 28'h000_0040 + 28'(i);
        return 28'hA00_0040 + 28'(i - 12);
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int lat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", mem_ready_data, 1'b0);
        check("rst_rd_data", mem_data_rd, '0);
        check("rst_wr_count", wr_count, 16'd0);
        check("rst_flags", {rd_miss, evict}, 2'b00);
        rst = 1'b0;

        // first write from idle, then read-back and a miss
        do_cmd(1'b1, 28'h000_0008, D1, lat);
        check("t1_latency", lat, LAT);
        check("t1_wr_count", wr_count, 16'd1);
        idle(1);
        do_cmd(1'b0, 28'h000_0008, '0, lat);
        check("t2_latency", lat, LAT);
        check("t2_rd_data", mem_data_rd, D1);
        check("t2_no_miss", rd_miss, 1'b0);

        // valid held high across ready: one completion per LAT+1 cycles
        do_cmd(1'b0, 28'h100_0008, '0, lat);
        check("t3_chain_lat", lat, LAT + 1);
        check("t2_fill", mem_data_rd, FILL);
        check("t2_miss", rd_miss, 1'b1);
        do_cmd(1'b0, 28'h100_0008, '0, lat);
        check("t3_chain_lat2", lat, LAT + 1);
        do_cmd(1'b0, 28'h000_0008, '0, lat);
        check("t2_miss_sticky", rd_miss, 1'b1);
        check("t2_reread", mem_data_rd, D1);
        check("t3_rd_count", rd_count, 16'd4);
        idle(3);

        // fill all entries plus one
        do_reset();
        for (int i = 0; i < 17; i++) begin
            do_cmd(1'b1, 28'h000_0100 + 28'(i), pat(i), lat);
            if (i == 15) check("t4_no_evict16", evict, 1'b0);
        end
        check("t4_evict17", evict, 1'b1);
        do_cmd(1'b0, 28'h000_0100, '0, lat);
        check("t4_first_miss", rd_miss, 1'b1);
        check("t4_first_fill", mem_data_rd, FILL);
        for (int i = 1; i < 17; i++) begin
            do_cmd(1'b0, 28'h000_0100 + 28'(i), '0, lat);
            check("t4_hit_data", mem_data_rd, pat(i));
        end
        idle(2);

        // rewrite existing address: no allocation
        do_reset();
        for (int i = 0; i < 3; i++) do_cmd(1'b1, 28'h000_0200 + 28'(i), pat(20 + i), lat);
        do_cmd(1'b1, 28'h000_0201, D5, lat);
        do_cmd(1'b0, 28'h000_0201, '0, lat);
        check("t5_new_data", mem_data_rd, D5);
        check("t5_no_evict", evict, 1'b0);
        for (int i = 3; i < 16; i++) do_cmd(1'b1, 28'h000_0200 + 28'(i), pat(20 + i), lat);
        check("t5_ptr_kept", evict, 1'b0);
        do_cmd(1'b1, 28'h000_0210, pat(40), lat);
        check("t5_evict", evict, 1'b1);
        do_cmd(1'b0, 28'h000_0200, '0, lat);
        check("t5_slot0_gone", rd_miss, 1'b1);
        idle(2);

        // reset in the middle of a write
        do_reset();
        rw = 1'b1;
        addr = 28'h000_0300;
        wr_d = D5;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("t6_wr_count", wr_count, 16'd0);
        do_cmd(1'b0, 28'h000_0300, '0, lat);
        check("t6_miss", rd_miss, 1'b1);
        check("t6_fill", mem_data_rd, FILL);
        check("t6_rd_count", rd_count, 16'd1);
        idle(2);

        // random traffic over a small address pool
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int g;
            do_cmd(1'($urandom_range(0, 1)), pool($urandom_range(0, 23)), rnd256(), lat);
            g = $urandom_range(0, 2);
            if (g != 0) idle(g);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
